// File: rtl/grasspopper_round_ctrl.sv
// Grasspopper round sequencer: 10-key bank, 128-bit state, one shared LSX unit for nine rounds plus the final key XOR.
// Latency: out_valid rises 10 cycles after the accept; the FSM returns to IDLE on the out_valid/out_ready handshake.
// Backpressure: in_ready is high only in IDLE; out_data and out_valid hold until out_ready.
module grasspopper_round_ctrl #(
    parameter int BLOCK_W = 128,
    parameter int NKEYS   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               key_we,
    input  logic [3:0]         key_idx,
    input  logic [BLOCK_W-1:0] key_data,
    output logic               key_err,
    output logic [BLOCK_W-1:0] lsx_data_o,
    output logic [BLOCK_W-1:0] lsx_key_o,
    input  logic [BLOCK_W-1:0] lsx_data_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [3:0]         rnd_q;
    logic [BLOCK_W-1:0] blk_q;
    logic [BLOCK_W-1:0] out_data_q;
    logic [BLOCK_W-1:0] keys_q [NKEYS];
    logic               out_valid_q;
    logic               key_err_q;
    logic               key_ok;

    // Keys are only writable while no block is in flight.
    assign key_ok = key_we && (fsm_q == IDLE) && (key_idx < 4'(NKEYS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        busy      = 1'b1;
        lsx_key_o = '0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    fsm_d = RUN;
                end
            end
            RUN: begin
                lsx_key_o = keys_q[rnd_q];
                if (rnd_q == 4'(NKEYS - 2)) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                fsm_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rnd_q       <= '0;
            blk_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            for (int i = 0; i < NKEYS; i++) begin
                keys_q[i] <= '0;
            end
        end else begin
            key_err_q <= key_we && !key_ok;
            if (key_ok) begin
                keys_q[key_idx] <= key_data;
            end
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        blk_q <= in_data;
                        rnd_q <= '0;
                    end
                end
                RUN: begin
                    blk_q <= lsx_data_i;
                    rnd_q <= rnd_q + 4'd1;
                end
                FINAL: begin
                    out_data_q  <= blk_q ^ keys_q[NKEYS-1];
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign lsx_data_o = blk_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign key_err    = key_err_q;

endmodule

// File: doc/grasspopper_round_ctrl.md
# grasspopper_round_ctrl

Iterative sequencer for the Grasspopper (GOST R 34.12-2015) encryption datapath. It owns a 10-entry round-key bank and a 128-bit cipher state register, and drives one shared combinational round unit (X, then S, then L) for nine rounds. It then applies the final key XOR itself and returns the ciphertext through a valid/ready handshake. It sits between the block-level host interface and the round unit, so one round unit serves every round instead of an unrolled pipeline.

## Interface
- BLOCK_W, 128, cipher block and round-key width
- NKEYS, 10, number of round keys (K1..K10, stored at indices 0..9)
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  plaintext block offered
- in_ready  out  1  block accepted when in_valid & in_ready
- in_data  in  BLOCK_W  plaintext
- key_we  in  1  round-key write strobe
- key_idx  in  4  round-key index 0..9
- key_data  in  BLOCK_W  round-key value
- key_err  out  1  one-cycle pulse: key write rejected
- lsx_data_o  out  BLOCK_W  state sent to round unit
- lsx_key_o  out  BLOCK_W  round key sent to round unit
- lsx_data_i  in  BLOCK_W  round-unit result L(S(lsx_data_o ^ lsx_key_o)), same cycle
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  BLOCK_W  ciphertext
- busy  out  1  high whenever FSM is not IDLE

## Operation
- FSM states: IDLE, RUN, FINAL, DONE. Round counter rnd has 4 bits and covers 0..8.
- IDLE: in_ready = 1. On accept: state <= in_data, rnd <= 0, go to RUN.
- RUN: each cycle state <= lsx_data_i and rnd <= rnd + 1. The round unit sees lsx_key_o = K[rnd]. When rnd == 8 completes, go to FINAL.
- FINAL: out_data <= state ^ K[9], out_valid <= 1, go to DONE.
- DONE: hold out_data and out_valid stable until out_ready. On the handshake edge: out_valid <= 0, go to IDLE.
- lsx_data_o = state register at all times. lsx_key_o = K[rnd] in RUN and 0 otherwise.
- in_ready = (FSM == IDLE). It is combinational and is 0 in RUN, FINAL and DONE.
- Key writes are accepted only in IDLE with key_idx <= 9: K[key_idx] <= key_data.
  - A write in any other state, or with key_idx >= 10, is dropped. key_err then pulses high for exactly the next cycle.
  - Key writes never alter a block already in flight.
- Key write and accept in the same IDLE cycle: both take effect, and that block uses the new key.
- All XORs are bitwise over BLOCK_W bits, with no carries. The key bank is not read-modified.
- Reset (asynchronous, any state, including mid-RUN or DONE):
  - FSM goes to IDLE and rnd to 0.
  - state, out_data and all K[i] go to 0.
  - out_valid, key_err and busy go to 0; in_ready reads 1.
  - An in-flight block is discarded without output.

## Timing
- Accept at edge E0. Rounds occur at edges E1..E9 and the final XOR at E10. out_valid is high from E10.
- Fixed latency: 10 cycles from accept to out_valid. This is independent of out_ready.
- If out_ready is high at E11, the FSM is back in IDLE after E11 and the next accept is possible at E12. Best-case throughput is 1 block per 12 cycles.
- out_ready stall of N cycles delays the return to IDLE by N cycles. out_data and out_valid must not change during the stall.
- The round unit is purely combinational. lsx_data_i is sampled on the same edge on which lsx_data_o and lsx_key_o are presented.
- key_err asserts the cycle after the offending write and lasts exactly 1 cycle. Back-to-back bad writes give back-to-back pulses.

## Test plan
- GOST vector:
  - Load K1..K10 expanded from key 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef (K1 = 8899aabbccddeeff0011223344556677, K2 = fedcba98765432100123456789abcdef).
  - Use a reference round unit and send 1122334455667700ffeeddccbbaa9988.
  - Required: out_data = 7f679d90bebc24305a468d42b9d4edcd, out_valid exactly 10 cycles after accept.
- Back-pressure: hold out_ready = 0 for 5 cycles after out_valid. Required: out_data stable, in_ready = 0, busy = 1. Release gives one transfer, then in_ready = 1 the next cycle.
- Back-to-back: offer two blocks with in_valid held high and out_ready tied to 1. Required: second accept exactly 12 cycles after the first, and both ciphertexts correct.
- Key protection:
  - A key_we with idx 3 issued during RUN gives a key_err pulse of 1 cycle; K[3] is unchanged and the result still matches the vector.
  - A write with key_idx = 12 in IDLE also gives a key_err pulse.
- Same-cycle write and accept: all keys set to 0, then K[0] = 1 written together with the accept of a zero block. Required: lsx_key_o = 1 during the first RUN cycle.
- Reset mid-operation: drop rst at the 4th RUN cycle. Required: outputs reach their reset values immediately. After release, in_ready = 1, no out_valid appears, and the key bank reads all zero (verify by zero-key encryption against the model).
